// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control bundle layout and reset/no-op constants.
package pipe_pkg;

   localparam int unsigned CTRL_W = 8;

   // Bit positions of the control byte as delivered by the decoder.
   localparam int unsigned CTRL_REG_WRITE  = 7;
   localparam int unsigned CTRL_MEM_TO_REG = 6;
   localparam int unsigned CTRL_MEM_READ   = 5;
   localparam int unsigned CTRL_MEM_WRITE  = 4;
   localparam int unsigned CTRL_ALU_SRC    = 3;
   localparam int unsigned CTRL_BRANCH     = 2;
   localparam int unsigned CTRL_ALU_OP_MSB = 1;
   localparam int unsigned CTRL_ALU_OP_LSB = 0;

   typedef struct packed {
      logic       reg_write;
      logic       mem_to_reg;
      logic       mem_read;
      logic       mem_write;
      logic       alu_src;
      logic       branch;
      logic [1:0] alu_op;
   } ctrl_t;

   typedef logic [4:0] reg_idx_t;

   localparam ctrl_t    CTRL_NOP = '0;
   localparam reg_idx_t REG_ZERO = 5'd0;

   // Unpack the raw decoder byte into named fields.
   function automatic ctrl_t ctrl_from_bits(input logic [CTRL_W-1:0] bits);
      ctrl_t c;
      c.reg_write  = bits[CTRL_REG_WRITE];
      c.mem_to_reg = bits[CTRL_MEM_TO_REG];
      c.mem_read   = bits[CTRL_MEM_READ];
      c.mem_write  = bits[CTRL_MEM_WRITE];
      c.alu_src    = bits[CTRL_ALU_SRC];
      c.branch     = bits[CTRL_BRANCH];
      c.alu_op     = bits[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB];
      return c;
   endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detection: a load in EX whose rd is read by the instruction in ID.
module load_use_detect
   import pipe_pkg::*;
(
   input  logic     ex_valid_i,
   input  logic     ex_mem_read_i,
   input  reg_idx_t ex_rd_i,
   input  logic     id_valid_i,
   input  reg_idx_t id_rs1_i,
   input  reg_idx_t id_rs2_i,
   input  logic     id_rs1_used_i,
   input  logic     id_rs2_used_i,
   output logic     hazard_o
);

   logic rs1_match;
   logic rs2_match;

   // x0 never carries a dependence, so a load targeting it is ignored.
   always_comb begin
      rs1_match = id_rs1_used_i && (ex_rd_i == id_rs1_i);
      rs2_match = id_rs2_used_i && (ex_rd_i == id_rs2_i);
      hazard_o  = ex_valid_i && ex_mem_read_i && (ex_rd_i != REG_ZERO) &&
                  (rs1_match || rs2_match) && id_valid_i;
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall generation and a bubble counter.
module id_ex_stage
   import pipe_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              hold_i,
   input  logic              flush_i,
   input  logic              id_valid_i,
   input  logic [4:0]        id_rs1_i,
   input  logic [4:0]        id_rs2_i,
   input  logic [4:0]        id_rd_i,
   input  logic              id_rs1_used_i,
   input  logic              id_rs2_used_i,
   input  logic [XLEN-1:0]   id_rs1_data_i,
   input  logic [XLEN-1:0]   id_rs2_data_i,
   input  logic [XLEN-1:0]   id_imm_i,
   input  logic [9:0]        id_funct_i,
   input  logic [CTRL_W-1:0] id_ctrl_i,
   output logic              ex_valid_o,
   output logic [4:0]        ex_rs1_o,
   output logic [4:0]        ex_rs2_o,
   output logic [4:0]        ex_rd_o,
   output logic [XLEN-1:0]   ex_rs1_data_o,
   output logic [XLEN-1:0]   ex_rs2_data_o,
   output logic [XLEN-1:0]   ex_imm_o,
   output logic [9:0]        ex_funct_o,
   output logic [CTRL_W-1:0] ex_ctrl_o,
   output logic              stall_o,
   output logic [CNT_W-1:0]  bubble_cnt_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             ex_valid_q,    ex_valid_d;
   reg_idx_t         ex_rs1_q,      ex_rs1_d;
   reg_idx_t         ex_rs2_q,      ex_rs2_d;
   reg_idx_t         ex_rd_q,       ex_rd_d;
   logic [XLEN-1:0]  ex_rs1_data_q, ex_rs1_data_d;
   logic [XLEN-1:0]  ex_rs2_data_q, ex_rs2_data_d;
   logic [XLEN-1:0]  ex_imm_q,      ex_imm_d;
   logic [9:0]       ex_funct_q,    ex_funct_d;
   ctrl_t            ex_ctrl_q,     ex_ctrl_d;
   logic [CNT_W-1:0] bubble_cnt_q,  bubble_cnt_d;

   logic hazard;
   logic take_bubble;

   load_use_detect u_load_use_detect (
      .ex_valid_i    (ex_valid_q),
      .ex_mem_read_i (ex_ctrl_q.mem_read),
      .ex_rd_i       (ex_rd_q),
      .id_valid_i    (id_valid_i),
      .id_rs1_i      (id_rs1_i),
      .id_rs2_i      (id_rs2_i),
      .id_rs1_used_i (id_rs1_used_i),
      .id_rs2_used_i (id_rs2_used_i),
      .hazard_o      (hazard)
   );

   // A squashed (wrong-path) instruction must never freeze the front end.
   assign stall_o     = hazard & ~flush_i;
   assign take_bubble = flush_i | hazard;

   // Next-state: bubble on flush/hazard (all fields zero so nothing forwards), else capture ID.
   always_comb begin
      ex_valid_d    = 1'b0;
      ex_rs1_d      = REG_ZERO;
      ex_rs2_d      = REG_ZERO;
      ex_rd_d       = REG_ZERO;
      ex_rs1_data_d = '0;
      ex_rs2_data_d = '0;
      ex_imm_d      = '0;
      ex_funct_d    = '0;
      ex_ctrl_d     = CTRL_NOP;
      if (!take_bubble) begin
         ex_valid_d    = id_valid_i;
         ex_rs1_d      = id_rs1_i;
         ex_rs2_d      = id_rs2_i;
         ex_rd_d       = id_rd_i;
         ex_rs1_data_d = id_rs1_data_i;
         ex_rs2_data_d = id_rs2_data_i;
         ex_imm_d      = id_imm_i;
         ex_funct_d    = id_funct_i;
         ex_ctrl_d     = id_valid_i ? ctrl_from_bits(id_ctrl_i) : CTRL_NOP;
      end
   end

   // Count only load-use bubbles, saturating at all-ones.
   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      if (stall_o && (bubble_cnt_q != CNT_MAX)) begin
         bubble_cnt_d = bubble_cnt_q + 1'b1;
      end
   end

   // State update; hold freezes the whole stage including the counter.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ex_valid_q    <= 1'b0;
         ex_rs1_q      <= REG_ZERO;
         ex_rs2_q      <= REG_ZERO;
         ex_rd_q       <= REG_ZERO;
         ex_rs1_data_q <= '0;
         ex_rs2_data_q <= '0;
         ex_imm_q      <= '0;
         ex_funct_q    <= '0;
         ex_ctrl_q     <= CTRL_NOP;
         bubble_cnt_q  <= '0;
      end else if (!hold_i) begin
         ex_valid_q    <= ex_valid_d;
         ex_rs1_q      <= ex_rs1_d;
         ex_rs2_q      <= ex_rs2_d;
         ex_rd_q       <= ex_rd_d;
         ex_rs1_data_q <= ex_rs1_data_d;
         ex_rs2_data_q <= ex_rs2_data_d;
         ex_imm_q      <= ex_imm_d;
         ex_funct_q    <= ex_funct_d;
         ex_ctrl_q     <= ex_ctrl_d;
         bubble_cnt_q  <= bubble_cnt_d;
      end
   end

   assign ex_valid_o    = ex_valid_q;
   assign ex_rs1_o      = ex_rs1_q;
   assign ex_rs2_o      = ex_rs2_q;
   assign ex_rd_o       = ex_rd_q;
   assign ex_rs1_data_o = ex_rs1_data_q;
   assign ex_rs2_data_o = ex_rs2_data_q;
   assign ex_imm_o      = ex_imm_q;
   assign ex_funct_o    = ex_funct_q;
   assign ex_ctrl_o     = ex_ctrl_q;
   assign bubble_cnt_o  = bubble_cnt_q;

endmodule
